// File: rtl/div_pkg.sv
// Shared types and helpers for the bit-serial divisibility checkers.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Remainder width for divisor d: max(1, clog2(d)).
  function automatic int unsigned rem_width(input int unsigned d);
    int unsigned w;
    w = $clog2(d);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_step.sv
// One MSB-first remainder step: next = (2*rem + bit) mod DIVISOR, by conditional subtract.
module mod_step
  import div_pkg::*;
#(
  parameter int unsigned DIVISOR = 5,
  localparam int unsigned RW = rem_width(DIVISOR)
) (
  input  logic [RW-1:0] rem_i,
  input  logic          bit_i,
  output logic [RW-1:0] next_rem_o
);

  // DIVISOR <= 2**RW, so it always fits in RW+1 bits alongside t.
  localparam logic [RW:0] DivW = (RW + 1)'(DIVISOR);

  logic [RW:0] t;
  logic [RW:0] t_sub;

  always_comb begin
    t          = {rem_i, bit_i};
    t_sub      = t - DivW;
    next_rem_o = (t >= DivW) ? t_sub[RW-1:0] : t[RW-1:0];
  end

endmodule

// File: rtl/serial_divk_checker.sv
// Bit-serial divisibility checker: streams a WIDTH-bit word MSB first and reports
// word mod DIVISOR plus a divisible flag, one word per WIDTH cycles sustained.
module serial_divk_checker
  import div_pkg::*;
#(
  parameter int unsigned DIVISOR = 5,
  parameter int unsigned WIDTH   = 8,
  localparam int unsigned RW = rem_width(DIVISOR),
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          bit_valid_i,
  input  logic          bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          div_o,
  output logic [RW-1:0] rem_o
);

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          div_q, div_d;
  logic [RW-1:0] rem_out_q, rem_out_d;

  logic          accept;
  logic [RW-1:0] rem_base;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic [RW-1:0] step_rem;

  // start_i restarts the word, so the step works from a cleared remainder/count.
  assign rem_base = start_i ? '0 : rem_q;
  assign cnt_base = start_i ? '0 : cnt_q;
  assign cnt_inc  = cnt_base + CW'(1);
  assign accept   = bit_valid_i && (start_i || (state_q == StShift));

  mod_step #(
    .DIVISOR(DIVISOR)
  ) u_mod_step (
    .rem_i      (rem_base),
    .bit_i      (bit_i),
    .next_rem_o (step_rem)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    div_d     = div_q;
    rem_out_d = rem_out_q;

    if (start_i) begin
      state_d   = StShift;
      rem_d     = '0;
      cnt_d     = '0;
      div_d     = 1'b0;
      rem_out_d = '0;
    end

    unique case (state_d)
      StShift: begin
        if (accept) begin
          rem_d = step_rem;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(WIDTH)) begin
            state_d   = StDone;
            done_d    = 1'b1;
            div_d     = (step_rem == '0);
            rem_out_d = step_rem;
          end
        end
      end
      StIdle, StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      rem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      div_q     <= div_d;
      rem_out_q <= rem_out_d;
    end
  end

  assign busy_o = (state_q == StShift);
  assign done_o = done_q;
  assign div_o  = div_q;
  assign rem_o  = rem_out_q;

endmodule

// File: tb/tb_serial_divk_checker.sv
// Bench for serial_divk_checker: three configurations (5/8, 3/4, 7/12) checked against
// plain modulo arithmetic on the assembled word.
module tb_serial_divk_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_s = '0;
  logic [2:0] bv_s = '0;
  logic [2:0] bit_s = '0;
  logic [2:0] busy_s;
  logic [2:0] done_s;
  logic [2:0] div_s;
  logic [2:0] rem0;
  logic [1:0] rem1;
  logic [2:0] rem2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int widths [3] = '{8, 4, 12};
  int divs   [3] = '{5, 3, 7};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_divk_checker #(.DIVISOR(5), .WIDTH(8)) u_d5 (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .bit_valid_i(bv_s[0]), .bit_i(bit_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .div_o(div_s[0]), .rem_o(rem0)
  );
  serial_divk_checker #(.DIVISOR(3), .WIDTH(4)) u_d3 (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .bit_valid_i(bv_s[1]), .bit_i(bit_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .div_o(div_s[1]), .rem_o(rem1)
  );
  serial_divk_checker #(.DIVISOR(7), .WIDTH(12)) u_d7 (
    .clk(clk), .rst(rst), .start_i(start_s[2]), .bit_valid_i(bv_s[2]), .bit_i(bit_s[2]),
    .busy_o(busy_s[2]), .done_o(done_s[2]), .div_o(div_s[2]), .rem_o(rem2)
  );

  function automatic int get_rem(input int k);
    case (k)
      0:       return int'(rem0);
      1:       return int'(rem1);
      default: return int'(rem2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams the top n bits of a width-bit value, starting with start_i plus first bit.
  // A maxgap > 0 inserts 1..maxgap idle cycles before each later bit.
  task automatic send_bits(input int k, input int value, input int n, input int maxgap);
    int w;
    w = widths[k];
    start_s[k] = 1'b1;
    bv_s[k]    = 1'b1;
    bit_s[k]   = 1'((value >> (w - 1)) & 1);
    tick();
    start_s[k] = 1'b0;
    for (int i = w - 2; i >= w - n; i--) begin
      chk("busy_mid", int'(busy_s[k]), 1);
      chk("no_early_done", int'(done_s[k]), 0);
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 1);
        for (int j = 0; j < g; j++) begin
          bv_s[k]  = 1'b0;
          bit_s[k] = 1'($urandom);
          tick();
          chk("gap_no_done", int'(done_s[k]), 0);
        end
      end
      bv_s[k]  = 1'b1;
      bit_s[k] = 1'((value >> i) & 1);
      tick();
    end
    bv_s[k] = 1'b0;
  endtask

  task automatic expect_done(input string name, input int k, input int value);
    int r;
    r = value % divs[k];
    chk({name, "_done"}, int'(done_s[k]), 1);
    chk({name, "_busy"}, int'(busy_s[k]), 0);
    chk({name, "_div"}, int'(div_s[k]), (r == 0) ? 1 : 0);
    chk({name, "_rem"}, get_rem(k), r);
  endtask

  // Stray bits in DONE without start_i must leave everything unchanged.
  task automatic hold_done(input string name, input int k, input int value, input int n);
    int r;
    r = value % divs[k];
    for (int j = 0; j < n; j++) begin
      bv_s[k]  = 1'($urandom);
      bit_s[k] = 1'($urandom);
      tick();
      chk({name, "_hold_done"}, int'(done_s[k]), 0);
      chk({name, "_hold_busy"}, int'(busy_s[k]), 0);
      chk({name, "_hold_div"}, int'(div_s[k]), (r == 0) ? 1 : 0);
      chk({name, "_hold_rem"}, get_rem(k), r);
    end
    bv_s[k] = 1'b0;
  endtask

  typedef struct {
    int value;
    int maxgap;
    int exp_div;
    int exp_rem;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int prev_cyc;
    vecs[0] = '{value: 'h0F, maxgap: 0, exp_div: 1, exp_rem: 0};
    vecs[1] = '{value: 'h11, maxgap: 0, exp_div: 0, exp_rem: 2};
    vecs[2] = '{value: 'hFF, maxgap: 0, exp_div: 1, exp_rem: 0};
    vecs[3] = '{value: 'h00, maxgap: 0, exp_div: 1, exp_rem: 0};
    vecs[4] = '{value: 'h11, maxgap: 5, exp_div: 0, exp_rem: 2};

    // Reset state, with stray inputs that reset must override.
    start_s = '1;
    bv_s    = '1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", int'(busy_s[k]), 0);
      chk("rst_done", int'(done_s[k]), 0);
      chk("rst_div", int'(div_s[k]), 0);
      chk("rst_rem", get_rem(k), 0);
    end
    start_s = '0;
    bv_s    = '0;
    rst     = 1'b0;
    tick();
    chk("idle_busy", int'(busy_s[0]), 0);
    chk("idle_rem", get_rem(0), 0);

    // Directed table for DIVISOR=5, WIDTH=8 with hand-computed results.
    foreach (vecs[v]) begin
      send_bits(0, vecs[v].value, 8, vecs[v].maxgap);
      chk("tbl_done", int'(done_s[0]), 1);
      chk("tbl_div", int'(div_s[0]), vecs[v].exp_div);
      chk("tbl_rem", get_rem(0), vecs[v].exp_rem);
      hold_done("tbl", 0, vecs[v].value, 3);
    end

    // Abort after 4 bits of 0x37, then a full 0x0A.
    send_bits(0, 'h37, 4, 0);
    chk("abort_busy", int'(busy_s[0]), 1);
    send_bits(0, 'h0A, 8, 0);
    chk("abort_div", int'(div_s[0]), 1);
    chk("abort_rem", get_rem(0), 0);
    expect_done("abort", 0, 'h0A);
    tick();
    chk("abort_single_done", int'(done_s[0]), 0);

    // Reset after 5 bits discards the word.
    send_bits(0, 'h5A, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bv_s[0] = 1'($urandom);
      tick();
      chk("midrst_done", int'(done_s[0]), 0);
      chk("midrst_busy", int'(busy_s[0]), 0);
      chk("midrst_div", int'(div_s[0]), 0);
      chk("midrst_rem", get_rem(0), 0);
    end
    bv_s[0] = 1'b0;

    // DIVISOR=3, WIDTH=4: exhaustive, back to back, one word per 4 cycles.
    prev_cyc = 0;
    for (int v = 0; v < 16; v++) begin
      send_bits(1, v, 4, 0);
      expect_done("d3", 1, v);
      if (v > 0) chk("d3_throughput", cyc - prev_cyc, 4);
      prev_cyc = cyc;
    end
    tick();
    chk("d3_last_done_clear", int'(done_s[1]), 0);

    // DIVISOR=7, WIDTH=12: random words, random gaps, stray bits in DONE.
    for (int n = 0; n < 1000; n++) begin
      int value;
      value = int'($urandom_range(4095, 0));
      send_bits(2, value, 12, ($urandom_range(3, 0) == 0) ? 2 : 0);
      expect_done("d7", 2, value);
      if ($urandom_range(3, 0) == 0) hold_done("d7", 2, value, int'($urandom_range(3, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_divk_checker.md
# serial_divk_checker

Bit-serial divisibility checker: accepts a WIDTH-bit word one bit per accepted beat, MSB first, and reports whether the word is divisible by a compile-time DIVISOR, together with the remainder. It generalises the team's 4-bit divide-by-5 minterm detector to arbitrary divisor and word length by tracking a running remainder instead of enumerating multiples. It sits on serial input paths (shift-register or UART-style streams) where the full word is never held in parallel.

## Interface

- DIVISOR, 5: divisor, integer ≥ 2.
- WIDTH, 8: bits per word, integer ≥ 2.
- RW (localparam), max(1, $clog2(DIVISOR)): remainder width.
- CW (localparam), $clog2(WIDTH+1): bit-counter width.

Ports:

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  begin a new word; clears remainder and counter.
- bit_valid_i  input  1  bit_i carries a valid data bit this cycle.
- bit_i  input  1  serial data bit, MSB first.
- busy_o  output  1  word in progress (state SHIFT).
- done_o  output  1  one-cycle pulse when a word completes.
- div_o  output  1  final word divisible by DIVISOR; valid in DONE.
- rem_o  output  RW  final remainder (word mod DIVISOR); valid in DONE.

## Operation

- States: IDLE, SHIFT, DONE.
- Remainder update per accepted bit: t = 2·rem + bit_i, with range 0..2·DIVISOR−1. rem' = (t ≥ DIVISOR) ? t − DIVISOR : t.
  - Compute t at RW+1 bits.
  - No divider or multiplier is used.
- A bit is accepted when bit_valid_i is high and either the state is SHIFT or start_i is high. Bits presented while not accepted are ignored.
- start_i in any state, SHIFT included (abort and restart):
  - rem ← 0, cnt ← 0, state → SHIFT.
  - If bit_valid_i is high in the same cycle, that bit is the new word's first bit: rem ← bit_i, cnt ← 1.
- SHIFT, accepted bit: rem and cnt update, cnt ← cnt + 1.
  - When the bit is the WIDTH-th, the state goes to DONE.
  - bit_valid_i low means hold; gaps of any length are allowed.
- DONE:
  - done_o is high for the first DONE cycle only.
  - div_o = (rem == 0) and rem_o = rem, both held stable until the next start_i.
  - Further bit_valid_i without start_i is ignored.
- IDLE: div_o = 0, rem_o = 0.
- Reset values:
  - state IDLE, rem 0, cnt 0.
  - busy_o 0, done_o 0, div_o 0, rem_o 0.
- Reset has priority over start_i and bit_valid_i. Reset mid-word discards the word and produces no done_o.
- WIDTH-bit all-zero word: div_o = 1, rem_o = 0.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- The WIDTH-th bit accepted at edge k gives state DONE, done_o = 1, and valid div_o/rem_o in cycle k+1.
- Latency from the first bit to done_o is at minimum WIDTH cycles with no gaps.
- Back-to-back words: start_i plus the first bit may arrive in the done_o cycle. That gives one word per WIDTH cycles sustained.
- busy_o is high from the cycle after start_i until the cycle after the last bit. It is low in the done_o cycle.

## Structure

- Shared package div_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - a function for remainder width (max(1, $clog2(D))) reused by other divisibility blocks.
- One sub-module, mod_step (parameter DIVISOR):
  - purely combinational;
  - inputs rem[RW-1:0] and bit, output next_rem;
  - implements the conditional subtract.
- The top block holds the FSM, bit counter and output registers.

## Test plan

- DIVISOR=5, WIDTH=8, word 0x0F streamed with no gaps → done_o one cycle after the 8th bit, div_o=1, rem_o=0.
- Same configuration, words 0x11, 0xFF and 0x00:
  - 0x11 → div_o=0, rem_o=2.
  - 0xFF → div_o=1, rem_o=0.
  - 0x00 → div_o=1, rem_o=0.
- Word 0x11 with random bit_valid_i gaps (1–5 cycles) → identical result. done_o exactly one cycle, and outputs held until the next start_i.
- Interrupted words:
  - start_i after 4 bits of 0x37, then full 0x0A → rem_o=0, div_o=1, and only one done_o.
  - rst asserted after 5 bits → all outputs 0 and no done_o.
- DIVISOR=3, WIDTH=4, exhaustive 0–15 back-to-back with start_i plus first bit in each done_o cycle → rem_o == value % 3 every word, throughput one word per 4 cycles.
- DIVISOR=7, WIDTH=12, 1000 random words against a reference model, including bit_valid_i asserted while in DONE without start_i → no state change.
